// File: rtl/sha3_padder.sv
// Input staging and pad insertion for the SHA3-512 core. It gathers 64-bit message words into a
// 576-bit rate block, adds the domain pad byte and zero fill, and holds the block until f_ack.
module sha3_padder #(
    parameter int         RATE_WORDS = 9,
    parameter logic [7:0] PAD_BYTE   = 8'h06
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [63:0]              in,
    input  logic [2:0]               byte_num,
    input  logic                     in_ready,
    input  logic                     is_last,
    output logic                     buffer_full,
    output logic [RATE_WORDS*64-1:0] out,
    output logic                     out_ready,
    input  logic                     f_ack
);

    localparam int        BLK_W    = RATE_WORDS * 64;
    localparam logic [3:0] LAST_IDX = 4'(RATE_WORDS - 1);

    typedef enum logic [1:0] {S_FILL, S_PAD, S_FULL, S_DONE} state_t;

    state_t             state_reg, state_next;
    logic [3:0]         cnt_reg, cnt_next;
    logic               last_seen_reg, last_seen_next;
    logic [BLK_W-1:0]   out_reg, out_next;
    logic               out_ready_reg, buffer_full_reg;
    logic [63:0]        padded_word;
    logic               accept;

    assign accept      = in_ready & ~buffer_full_reg;
    assign out         = out_reg;
    assign out_ready   = out_ready_reg;
    assign buffer_full = buffer_full_reg;

    // Final word: keep bytes below byte_num, put the pad byte at byte_num, and zero everything after it.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pad
            localparam int HI = 63 - 8 * gi;
            assign padded_word[HI -: 8] =
                (4'(gi) <  {1'b0, byte_num}) ? in[HI -: 8] :
                (4'(gi) == {1'b0, byte_num}) ? PAD_BYTE    : 8'h00;
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        last_seen_next = last_seen_reg;
        out_next       = out_reg;
        case (state_reg)
            S_FILL: begin
                if (accept) begin
                    cnt_next = cnt_reg + 4'd1;
                    if (is_last) begin
                        out_next       = {out_reg[BLK_W-65:0], padded_word};
                        last_seen_next = 1'b1;
                        state_next     = (cnt_reg == LAST_IDX) ? S_FULL : S_PAD;
                    end else begin
                        out_next   = {out_reg[BLK_W-65:0], in};
                        state_next = (cnt_reg == LAST_IDX) ? S_FULL : S_FILL;
                    end
                end
            end
            S_PAD: begin
                out_next = {out_reg[BLK_W-65:0], 64'd0};
                cnt_next = cnt_reg + 4'd1;
                if (cnt_reg == LAST_IDX)
                    state_next = S_FULL;
            end
            S_FULL: begin
                if (f_ack) begin
                    cnt_next   = 4'd0;
                    state_next = last_seen_reg ? S_DONE : S_FILL;
                end
            end
            default: ;
        endcase
    end

    // The handshake outputs are decoded from the next state, so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_FILL;
            cnt_reg         <= 4'd0;
            last_seen_reg   <= 1'b0;
            out_reg         <= '0;
            out_ready_reg   <= 1'b0;
            buffer_full_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            last_seen_reg   <= last_seen_next;
            out_reg         <= out_next;
            out_ready_reg   <= (state_next == S_FULL);
            buffer_full_reg <= (state_next != S_FILL);
        end
    end

endmodule

// File: doc/sha3_padder.md
# sha3_padder

Input staging and padding block for the SHA3-512 core. Collects a byte-aligned message as 64-bit words, applies the SHA-3 domain pad byte after the final message byte, zero-fills the rest of the block, and presents each 576-bit rate block to `f_permutation`. It is the producer side of the permutation's `in`/`in_ready`/`ack` handshake. The terminal pad bit (0x80 in the last rate byte) is applied by the permutation on acceptance, not here.

## Interface
- `RATE_WORDS`, 9: 64-bit words per rate block (576 bits); fixed for SHA3-512.
- `PAD_BYTE`, 8'h06: domain-separation pad byte inserted after the last message byte.

- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `in`  in  64  message word; first byte in `in[63:56]`.
- `byte_num`  in  3  valid bytes in `in` when `is_last`=1 (0..7); ignored otherwise.
- `in_ready`  in  1  `in` valid this cycle.
- `is_last`  in  1  this word is the final (possibly empty) word of the message.
- `buffer_full`  out  1  1 = block not accepting words this cycle.
- `out`  out  576  rate block; word 0 in `out[575:512]`, word 8 in `out[63:0]`.
- `out_ready`  out  1  `out` holds a complete block.
- `f_ack`  in  1  permutation has consumed `out` this cycle.

## Operation
- Accept condition: `accept = in_ready & ~buffer_full`. Words outside accept are dropped; the source must hold until accepted.
- Storage: 576-bit shift register, new word enters at `out[63:0]`, shifts left 64 per stored word; 4-bit word counter `cnt` 0..9.
- States:
  - FILL: accept words. Non-last word: store `in`, `cnt++`. Last word with `byte_num`=n: store bytes 0..n-1 of `in`, byte n = `PAD_BYTE`, bytes n+1..7 = 0; `cnt++`; go PAD (or FULL if `cnt` reaches 9), set `last_seen`.
  - PAD: store one all-zero word per cycle, `cnt++`, until `cnt`=9, then FULL.
  - FULL: `out_ready`=1; wait for `f_ack`. On `f_ack`: `cnt`<=0; go DONE if `last_seen`, else FILL.
  - DONE: message finished; ignore input until reset.
- `cnt`=9 in FILL (non-last 9th word) -> FULL.
- `buffer_full` = 1 in PAD, FULL, DONE; 0 in FILL.
- Message length multiple of 72 bytes: final word is sent with `is_last`=1, `byte_num`=0 at the start of a new block -> word 0x0600_0000_0000_0000 followed by 8 zero words.
- Empty message: single `is_last`, `byte_num`=0 word -> one block.
- `f_ack` outside FULL: ignored.
- Reset mid-operation: all state discarded at next edge, back to FILL with `cnt`=0.

## Timing
- Reset values: `out`=0, `out_ready`=0, `buffer_full`=0, state FILL, `cnt`=0, `last_seen`=0.
- One word stored per accepting edge; throughput 1 word/cycle in FILL.
- `out_ready` and `buffer_full` are registered: high in the cycle after the edge storing word 9.
- Last word at position k (0-based): PAD occupies 8-k cycles; `out_ready` rises 9-k cycles after the accepting edge.
- `f_ack` in FULL: `out_ready`=0 and (non-final) `buffer_full`=0 the next cycle; earliest next word accepted the cycle after `f_ack`. `out` stays stable from `out_ready` rise through the `f_ack` cycle.
- In DONE, `out` holds the last block; `out_ready`=0, `buffer_full`=1.

## Test plan
- Reset -> `out`=0, `out_ready`=0, `buffer_full`=0; asserting reset while in PAD returns these values next cycle.
- Empty message (`is_last`=1, `byte_num`=0) -> after 9 cycles `out_ready`=1, `out[575:512]`=64'h0600_0000_0000_0000, rest 0; `f_ack` -> DONE, `buffer_full` stays 1.
- 3 bytes "abc" (`in`=64'h6162_63xx_xxxx_xxxx, `byte_num`=3, last) -> word 0 = 64'h6162_6306_0000_0000, words 1..8 = 0.
- 9 full words 1..9 then last word `byte_num`=0 -> block 1 = words 1..9 with no pad, `out_ready` held until `f_ack`; block 2 word 0 = 64'h0600..00, then DONE.
- 8 full words then last with `byte_num`=7 -> word 8 = first 7 bytes + 0x06, no PAD cycles, `out_ready` next cycle.
- Backpressure: `in_ready` held high during FULL with delayed `f_ack` (5 cycles) -> no word stored until the cycle after `f_ack`; spurious `f_ack` in FILL changes nothing.
